// File: rtl/dcw_sampler_pkg.sv
// Shared width constants for the DTC control word, also used by the digital
// loop and the behavioural DTC model.
package dcw_sampler_pkg;

  localparam int DTC_L  = 12;
  localparam int MSB_L  = 3;
  localparam int TEMP_L = (1 << MSB_L) - 1;
  localparam int BIN_L  = DTC_L - MSB_L;

  // One pipeline stage: the raw word and its thermometer decode travel together.
  typedef struct packed {
    logic [TEMP_L-1:0] temp;
    logic [DTC_L-1:0]  word;
  } dcw_stage_t;

endpackage

// File: rtl/dcw_sampler_if.sv
// Bundle between the DTC/MMD controller (master) and the sampler (slave).
interface dcw_sampler_if;
  import dcw_sampler_pkg::*;

  logic [DTC_L-1:0]  dcwin;
  logic [DTC_L-1:0]  dcwout;
  logic [TEMP_L-1:0] temp_code;
  logic [BIN_L-1:0]  binary_out;

  modport master (output dcwin, input dcwout, temp_code, binary_out);
  modport slave  (input dcwin, output dcwout, temp_code, binary_out);

endinterface

// File: rtl/dcw_sampler_therm_dec.sv
// Combinational MSB-to-thermometer decoder: bit i is set when the input value exceeds i.
module therm_dec #(
  parameter int MSB_W  = 3,
  parameter int TEMP_W = (1 << MSB_W) - 1
) (
  input  logic [MSB_W-1:0]  bin_i,
  output logic [TEMP_W-1:0] therm_o
);

  for (genvar i = 0; i < TEMP_W; i++) begin : g_bit
    assign therm_o[i] = (bin_i > MSB_W'(i));
  end

endmodule

// File: rtl/dcw_sampler.sv
// Samples the DTC control word on REFDTC and presents the registered word plus
// its thermometer/binary segments, all taken directly from the last flop stage.
module dcw_sampler
  import dcw_sampler_pkg::*;
#(
  parameter int PIPE = 1
) (
  input  logic              REFDTC,
  input  logic              SPI_NARST,
  input  logic [DTC_L-1:0]  DCWIN,
  output logic [DTC_L-1:0]  DCWOUT,
  output logic [TEMP_L-1:0] LOOP_TEMP_CODE,
  output logic [BIN_L-1:0]  LOOP_BINARY_OUT
);

  logic [TEMP_L-1:0] temp_in;

  therm_dec #(
    .MSB_W  (MSB_L),
    .TEMP_W (TEMP_L)
  ) u_therm_dec (
    .bin_i   (DCWIN[DTC_L-1:BIN_L]),
    .therm_o (temp_in)
  );

  // Decoding ahead of the first register keeps every output bit a bare flop Q.
  dcw_stage_t stage_d [PIPE];
  dcw_stage_t stage_q [PIPE];

  always_comb begin
    stage_d[0] = '{temp: temp_in, word: DCWIN};
    for (int i = 1; i < PIPE; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge REFDTC or negedge SPI_NARST) begin
    if (!SPI_NARST) begin
      for (int i = 0; i < PIPE; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PIPE; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign DCWOUT          = stage_q[PIPE-1].word;
  assign LOOP_TEMP_CODE  = stage_q[PIPE-1].temp;
  assign LOOP_BINARY_OUT = stage_q[PIPE-1].word[BIN_L-1:0];

endmodule

// File: tb/tb_dcw_sampler.sv
// Directed bench for dcw_sampler: reset, thermometer sweep, boundaries,
// latency, asynchronous mid-run reset and segment coherence.
module tb_dcw_sampler;
  import dcw_sampler_pkg::*;

  localparam int PIPE = 1;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  dcw_sampler_if bus ();

  dcw_sampler #(.PIPE(PIPE)) dut (
    .REFDTC          (clk),
    .SPI_NARST       (rst_n),
    .DCWIN           (bus.dcwin),
    .DCWOUT          (bus.dcwout),
    .LOOP_TEMP_CODE  (bus.temp_code),
    .LOOP_BINARY_OUT (bus.binary_out)
  );

  // clock/reset block
  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver: hold a word for PIPE edges, then settle 1 ns past the edge
  task automatic drive_word(input logic [DTC_L-1:0] w);
    bus.dcwin = w;
    repeat (PIPE) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [27:0] obs;
    bus.dcwin = 12'hABC;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      obs = {bus.dcwout, bus.temp_code, bus.binary_out};
      n_vec++;
      if (obs !== 28'h0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got %h want %h", i, obs, 28'h0);
      end
    end
    rst_n = 1'b1;
    drive_word(12'hABC);
    obs = {bus.dcwout, bus.temp_code, bus.binary_out};
    n_vec++;
    if (obs !== {12'hABC, 7'b0011111, 9'h0BC}) begin
      n_err++;
      $display("FAIL reset_release: got %h want %h", obs, {12'hABC, 7'b0011111, 9'h0BC});
    end
  endtask

  task automatic test_therm_sweep();
    logic [6:0]  exp_t [8];
    logic [11:0] w;
    logic [27:0] obs;
    exp_t = '{7'h00, 7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h7F};
    for (int m = 0; m < 8; m++) begin
      w = 12'(m) << 9;
      drive_word(w);
      obs = {bus.dcwout, bus.temp_code, bus.binary_out};
      n_vec++;
      if (obs !== {w, exp_t[m], 9'h000}) begin
        n_err++;
        $display("FAIL sweep_m%0d: got %h want %h", m, obs, {w, exp_t[m], 9'h000});
      end
    end
  endtask

  task automatic test_boundaries();
    logic [11:0] w_t [3];
    logic [6:0]  t_t [3];
    logic [8:0]  b_t [3];
    logic [27:0] obs;
    w_t = '{12'hFFF, 12'h1FF, 12'h5A5};
    t_t = '{7'h7F, 7'h00, 7'b0000011};
    b_t = '{9'h1FF, 9'h1FF, 9'h1A5};
    for (int i = 0; i < 3; i++) begin
      drive_word(w_t[i]);
      obs = {bus.dcwout, bus.temp_code, bus.binary_out};
      n_vec++;
      if (obs !== {w_t[i], t_t[i], b_t[i]}) begin
        n_err++;
        $display("FAIL boundary_%h: got %h want %h", w_t[i], obs, {w_t[i], t_t[i], b_t[i]});
      end
    end
  endtask

  // scoreboard: each sampled word becomes due PIPE edges after it was captured
  task automatic test_latency();
    logic [DTC_L-1:0] exp_q [$];
    logic [DTC_L-1:0] r;
    logic [DTC_L-1:0] e;
    logic [6:0]       e_t;
    logic [27:0]      obs;
    for (int c = 0; c < 1000; c++) begin
      r = 12'($urandom_range(0, 4095));
      bus.dcwin = r;
      @(posedge clk);
      #1;
      exp_q.push_back(r);
      if (exp_q.size() == PIPE) begin
        e   = exp_q.pop_front();
        e_t = 7'((8'd1 << e[11:9]) - 8'd1);
        obs = {bus.dcwout, bus.temp_code, bus.binary_out};
        n_vec++;
        if (obs !== {e, e_t, e[8:0]}) begin
          n_err++;
          $display("FAIL latency_c%0d: got %h want %h", c, obs, {e, e_t, e[8:0]});
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [27:0] obs;
    drive_word(12'h7FF);
    obs = {bus.dcwout, bus.temp_code, bus.binary_out};
    n_vec++;
    if (obs !== {12'h7FF, 7'h07, 9'h1FF}) begin
      n_err++;
      $display("FAIL midrst_pre: got %h want %h", obs, {12'h7FF, 7'h07, 9'h1FF});
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs = {bus.dcwout, bus.temp_code, bus.binary_out};
    n_vec++;
    if (obs !== 28'h0) begin
      n_err++;
      $display("FAIL midrst_clear: got %h want %h", obs, 28'h0);
    end
    #2;
    rst_n = 1'b1;
    bus.dcwin = 12'h123;
    #1;
    obs = {bus.dcwout, bus.temp_code, bus.binary_out};
    n_vec++;
    if (obs !== 28'h0) begin
      n_err++;
      $display("FAIL midrst_hold: got %h want %h", obs, 28'h0);
    end
    drive_word(12'h123);
    obs = {bus.dcwout, bus.temp_code, bus.binary_out};
    n_vec++;
    if (obs !== {12'h123, 7'h00, 9'h123}) begin
      n_err++;
      $display("FAIL midrst_resume: got %h want %h", obs, {12'h123, 7'h00, 9'h123});
    end
  endtask

  // samples both just after the edge and at mid-cycle to catch any mixed word
  task automatic test_coherence();
    logic [11:0] w;
    logic [27:0] want;
    logic [27:0] obs;
    for (int c = 0; c < 20; c++) begin
      w    = c[0] ? 12'h200 : 12'h1FF;
      want = c[0] ? {12'h200, 7'h01, 9'h000} : {12'h1FF, 7'h00, 9'h1FF};
      drive_word(w);
      obs = {bus.dcwout, bus.temp_code, bus.binary_out};
      n_vec++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL coherence_c%0d: got %h want %h", c, obs, want);
      end
      #3;
      obs = {bus.dcwout, bus.temp_code, bus.binary_out};
      n_vec++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL coherence_mid_c%0d: got %h want %h", c, obs, want);
      end
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    bus.dcwin = '0;
    test_reset();
    test_therm_sweep();
    test_boundaries();
    test_latency();
    test_mid_reset();
    test_coherence();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
